multiply_tokens: RTL and testbench
==================================

Name: multiply_tokens

Overview:
- Serial token expander: every '1' on input a produces FACTOR '1' tokens on output b. Tokens are emitted one per cycle, in order, as early as possible.
- Counterpart of the halving block. It sits on the same single-bit token stream, on the producer side, where the downstream consumer needs a multiplied token rate.
- A saturating pending-token counter buffers bursts. A stall input holds emission.

Parameters:
- FACTOR, 2, number of output tokens per input token; legal range 1..8.
- MAX_PENDING, 15, capacity of the pending-token buffer; must be >= FACTOR.
- CNT_W, derived as $clog2(MAX_PENDING+FACTOR+1), width of the internal sum and counter; not overridden by users.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- a  input  1  incoming token stream; 1 = one token this cycle.
- stall  input  1  1 = downstream cannot accept; b forced 0; tokens keep accumulating.
- b  output  1  outgoing token stream.
- pending  output  CNT_W  registered count of buffered, not-yet-emitted tokens.
- busy  output  1  pending != 0.
- overflow  output  1  sticky flag: at least one token was dropped because the buffer saturated.

Behaviour:
- Reset (rst=0, asynchronous):
  - pending=0, overflow=0, busy=0.
  - b is gated to 0 while rst=0, regardless of a.
  - Reset mid-burst discards all buffered tokens.
- Emission (combinational, zero latency): b = rst & !stall & (a | (pending != 0)).
  - A token arriving with pending==0 and stall=0 drives b=1 in the same cycle.
- Counter update each rising edge when rst=1:
  - sum = pending + (a ? FACTOR : 0) - (b ? 1 : 0), computed at CNT_W bits, no wrap possible.
  - If sum <= MAX_PENDING: pending <= sum.
  - Otherwise pending <= MAX_PENDING and overflow <= 1; the excess tokens are lost.
- overflow is cleared only by reset.
- Simultaneous arrival and emission: a=1 with b=1 gives a net change of FACTOR-1.
- stall=1: b=0, nothing is consumed, and arrivals still add FACTOR (subject to saturation).
- FACTOR=1 with stall=0: b equals a combinationally and pending stays 0 (pure pass-through).
- Output order is preserved: tokens drain continuously at one per cycle until pending==0.
- There is no token loss except at saturation.
- busy = (pending != 0), derived from the register.
- The state machine is implicit in the counter: IDLE (pending=0) and DRAIN (pending>0).
  - IDLE->DRAIN when sum > 0.
  - DRAIN->IDLE when sum == 0.

Decomposition:
- Shared package token_pkg holds:
  - the MAX_FACTOR=8 constant;
  - a function token_cnt_width(max_pending, factor) returning CNT_W;
  - typedef token_cnt_t parameterised via that function, used by any token-stream blocks that need counters.
- One sub-module: token_credit_counter.
  - Saturating up-by-N/down-by-1 counter.
  - Ports: clk, rst, inc, dec, count, sat_pulse.
  - multiply_tokens instantiates it and adds the emission logic and the sticky overflow register.

Test Plan:
- Burst (FACTOR=2, stall=0): a = 1100_0000 -> b = 1111_0000; pending per cycle = 1,2,1,0,0…; busy high in cycles 0-2.
- Sparse input (FACTOR=2): a = 1000_1000 -> b = 1100_1100; overflow stays 0.
- Stall hold (FACTOR=3): a=1 for 2 cycles with stall=1, then stall=0 -> pending reaches 6; then b=1 for exactly 6 consecutive cycles; pending reaches 0.
- Saturation (FACTOR=2, MAX_PENDING=15): stall=1 with a=1 for 9 cycles -> pending clamps at 15 on the 8th arrival; overflow rises and stays 1; after release, b emits exactly 15 tokens.
- Reset mid-drain: pending=5, drive rst=0 asynchronously between edges -> pending=0, b=0, overflow=0 immediately; after release with a=0, b stays 0.
- Pass-through (FACTOR=1): random a for 200 cycles, stall=0 -> b==a every cycle; pending stays 0.

Source files
------------

// File: rtl/token_pkg.sv
// Shared definitions for single-bit token-stream blocks (expanders, halvers).
package token_pkg;

    localparam int MAX_FACTOR = 8;

    localparam int DEF_FACTOR      = 2;
    localparam int DEF_MAX_PENDING = 15;

    // Counter width that holds pending + one full arrival without wrapping.
    function automatic int token_cnt_width(input int max_pending, input int factor);
        return $clog2(max_pending + factor + 1);
    endfunction

    localparam int DEF_CNT_W = token_cnt_width(DEF_MAX_PENDING, DEF_FACTOR);

    typedef logic [DEF_CNT_W-1:0] token_cnt_t;

endpackage

// File: rtl/multiply_tokens_counter.sv
// Saturating credit counter: +INC_N on inc, -1 on dec, clamped at MAX_COUNT.
module token_credit_counter
    import token_pkg::*;
#(
    parameter int INC_N     = DEF_FACTOR,
    parameter int MAX_COUNT = DEF_MAX_PENDING,
    parameter int CNT_W     = token_cnt_width(MAX_COUNT, INC_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             sat_pulse
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] add_s;
    logic [CNT_W-1:0] sub_s;
    logic [CNT_W-1:0] sum_s;
    logic [CNT_W-1:0] next_s;
    logic             sat_s;

    // Next-count arithmetic; a decrement with nothing to consume is ignored.
    always_comb begin
        add_s  = {CNT_W{1'b0}};
        sub_s  = {CNT_W{1'b0}};
        sum_s  = {CNT_W{1'b0}};
        next_s = count_r;
        sat_s  = 1'b0;
        if (inc) begin
            add_s = CNT_W'(INC_N);
        end else begin
            add_s = {CNT_W{1'b0}};
        end
        if (dec && ((count_r != {CNT_W{1'b0}}) || inc)) begin
            sub_s = CNT_W'(1'b1);
        end else begin
            sub_s = {CNT_W{1'b0}};
        end
        sum_s = count_r + add_s - sub_s;
        if (sum_s > CNT_W'(MAX_COUNT)) begin
            next_s = CNT_W'(MAX_COUNT);
            sat_s  = 1'b1;
        end else begin
            next_s = sum_s;
            sat_s  = 1'b0;
        end
    end

    // Count register; reset discards all buffered credits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= next_s;
        end
    end

    assign count     = count_r;
    assign sat_pulse = sat_s;

endmodule

// File: rtl/multiply_tokens.sv
// Serial token expander: each input token becomes FACTOR output tokens,
// emitted one per cycle with zero latency, held off by stall.
module multiply_tokens
    import token_pkg::*;
#(
    parameter int FACTOR      = DEF_FACTOR,
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    parameter int CNT_W       = token_cnt_width(MAX_PENDING, FACTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             stall,
    output logic             b,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    logic [CNT_W-1:0] count_s;
    logic             sat_s;
    logic             b_s;
    logic             overflow_r;

    // Emit whenever a token is available this cycle and downstream accepts.
    always_comb begin
        b_s = 1'b0;
        if (rst && !stall && (a || (count_s != {CNT_W{1'b0}}))) begin
            b_s = 1'b1;
        end else begin
            b_s = 1'b0;
        end
    end

    token_credit_counter #(
        .INC_N     (FACTOR),
        .MAX_COUNT (MAX_PENDING),
        .CNT_W     (CNT_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .inc       (a),
        .dec       (b_s),
        .count     (count_s),
        .sat_pulse (sat_s)
    );

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (sat_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign b        = b_s;
    assign pending  = count_s;
    assign busy     = (count_s != {CNT_W{1'b0}});
    assign overflow = overflow_r;

endmodule

// File: tb/tb_multiply_tokens.sv
// Directed bench for multiply_tokens at FACTOR = 2, 3 and 1.
module tb_multiply_tokens;

    logic       clk;
    logic       rst;
    logic       a1, s1, a2, s2, a3, s3;
    logic       b1, b2, b3;
    logic [4:0] p1, p2, p3;
    logic       busy1, busy2, busy3;
    logic       ov1, ov2, ov3;

    int total;
    int bad;

    multiply_tokens #(.FACTOR(1), .MAX_PENDING(15)) u1 (
        .clk(clk), .rst(rst), .a(a1), .stall(s1),
        .b(b1), .pending(p1), .busy(busy1), .overflow(ov1)
    );

    multiply_tokens #(.FACTOR(2), .MAX_PENDING(15)) u2 (
        .clk(clk), .rst(rst), .a(a2), .stall(s2),
        .b(b2), .pending(p2), .busy(busy2), .overflow(ov2)
    );

    multiply_tokens #(.FACTOR(3), .MAX_PENDING(15)) u3 (
        .clk(clk), .rst(rst), .a(a3), .stall(s3),
        .b(b3), .pending(p3), .busy(busy3), .overflow(ov3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle on the FACTOR=2 instance; checks are taken before the edge.
    task automatic step2(input string tag, input logic ai, input logic si,
                         input logic eb, input int ep, input logic eo);
        a2 = ai;
        s2 = si;
        @(negedge clk);
        chk({tag, " b"}, 32'(b2), 32'(eb));
        chk({tag, " pending"}, 32'(p2), 32'(ep));
        chk({tag, " busy"}, 32'(busy2), 32'(ep != 0));
        chk({tag, " overflow"}, 32'(ov2), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input string tag, input logic ai, input logic si,
                         input logic eb, input int ep);
        a3 = ai;
        s3 = si;
        @(negedge clk);
        chk({tag, " b"}, 32'(b3), 32'(eb));
        chk({tag, " pending"}, 32'(p3), 32'(ep));
        chk({tag, " overflow"}, 32'(ov3), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] av;
        logic [7:0] bv;
        int         pv [8];
        logic       r;

        total = 0;
        bad   = 0;
        rst = 1'b0;
        a1 = 1'b0; s1 = 1'b0;
        a2 = 1'b1; s2 = 1'b0;
        a3 = 1'b0; s3 = 1'b0;

        // Reset state, with a token offered: b must stay gated.
        #12;
        chk("reset b", 32'(b2), 32'(0));
        chk("reset pending", 32'(p2), 32'(0));
        chk("reset busy", 32'(busy2), 32'(0));
        chk("reset overflow", 32'(ov2), 32'(0));
        a2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Burst: a = 1100_0000 -> b = 1111_0000.
        av = 8'b1100_0000;
        bv = 8'b1111_0000;
        pv = '{0, 1, 2, 1, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            step2($sformatf("burst c%0d", i), av[7-i], 1'b0, bv[7-i], pv[i], 1'b0);
        end

        // Sparse: a = 1000_1000 -> b = 1100_1100.
        av = 8'b1000_1000;
        bv = 8'b1100_1100;
        pv = '{0, 1, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            step2($sformatf("sparse c%0d", i), av[7-i], 1'b0, bv[7-i], pv[i], 1'b0);
        end

        // Stall hold at FACTOR=3: 6 tokens accumulate, then drain back to back.
        step3("hold c0", 1'b1, 1'b1, 1'b0, 0);
        step3("hold c1", 1'b1, 1'b1, 1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            step3($sformatf("drain3 c%0d", i), 1'b0, 1'b0, 1'b1, 6 - i);
        end
        step3("drain3 end", 1'b0, 1'b0, 1'b0, 0);

        // Saturation: clamp at 15 on the 8th stalled arrival, overflow sticks.
        for (int i = 0; i < 8; i++) begin
            step2($sformatf("sat c%0d", i), 1'b1, 1'b1, 1'b0, 2 * i, 1'b0);
        end
        step2("sat c8", 1'b1, 1'b1, 1'b0, 15, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step2($sformatf("satdrain c%0d", i), 1'b0, 1'b0, 1'b1, 15 - i, 1'b1);
        end
        step2("satdrain end", 1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Build pending=5 with overflow still set, then reset between edges.
        step2("pre5 c0", 1'b1, 1'b1, 1'b0, 0, 1'b1);
        step2("pre5 c1", 1'b1, 1'b1, 1'b0, 2, 1'b1);
        step2("pre5 c2", 1'b1, 1'b1, 1'b0, 4, 1'b1);
        step2("pre5 c3", 1'b0, 1'b0, 1'b1, 6, 1'b1);
        chk("pre-reset pending", 32'(p2), 32'(5));
        #2;
        rst = 1'b0;
        #1;
        chk("async rst pending", 32'(p2), 32'(0));
        chk("async rst b", 32'(b2), 32'(0));
        chk("async rst busy", 32'(busy2), 32'(0));
        chk("async rst overflow", 32'(ov2), 32'(0));
        a2 = 1'b1;
        #1;
        chk("rst gates b", 32'(b2), 32'(0));
        a2 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step2($sformatf("post rst c%0d", i), 1'b0, 1'b0, 1'b0, 0, 1'b0);
        end

        // Pass-through at FACTOR=1: b follows a, nothing is buffered.
        for (int i = 0; i < 200; i++) begin
            r  = 1'($urandom_range(0, 1));
            a1 = r;
            s1 = 1'b0;
            @(negedge clk);
            chk($sformatf("pass b c%0d", i), 32'(b1), 32'(r));
            chk($sformatf("pass pending c%0d", i), 32'(p1), 32'(0));
            @(posedge clk);
            #1;
        end
        chk("pass overflow", 32'(ov1), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
